parity_frame_sequencer: RTL and testbench
=========================================

# parity_frame_sequencer

Byte-stream front end for the `parity_1` parity unit. Accepts bytes over a valid/ready input and buffers them in a small FIFO. Launches the parity unit once per byte and waits on its busy/result flags. Emits 9-bit framed words {parity_bit, byte} over a valid/ready output to the downstream serialiser.

## Interface
Parameters:
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2.
- TIMEOUT, 63: maximum cycles from launch to busy falling before the byte is abandoned.
- PAR_ODD, 0: 0 = even-parity frames (parity_bit = p_odd); 1 = odd-parity frames (parity_bit = p_even).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  8  byte to frame.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO not full.
- out_frame  out  9  {parity_bit, byte}.
- out_valid  out  1  out_frame valid; held until accepted.
- out_ready  in  1  downstream accepts.
- p_start  out  1  start pulse to parity unit.
- p_data  out  8  data_in to parity unit.
- p_busy  in  1  parity unit busy.
- p_even  in  1  parity unit even_parity flag.
- p_odd  in  1  parity unit odd_parity flag.
- err_timeout  out  1  one-cycle pulse: byte abandoned on timeout.
- err_flag  out  1  one-cycle pulse: p_even == p_odd at capture, byte dropped.
- frame_count  out  16  frames accepted downstream; wraps 0xFFFF→0.

## Operation
- Reset values: in_ready=1 (FIFO empty), out_frame=0, out_valid=0, p_start=0, p_data=0, err_timeout=0, err_flag=0, frame_count=0, state=IDLE, timeout counter=0.
- FIFO push when in_valid & in_ready. Pop only in CAPTURE or on timeout. Push and pop in the same cycle leave the occupancy unchanged. in_ready=0 when full. Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: go to LAUNCH when FIFO non-empty & !out_valid & !p_busy. Register p_data ← FIFO head.
  - LAUNCH: p_start=1 for exactly this one cycle. Clear timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for p_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for p_busy=0, then go to CAPTURE.
  - CAPTURE: pop FIFO.
    - If p_even ^ p_odd: out_frame ← {PAR_ODD ? p_even : p_odd, p_data}, out_valid ← 1.
    - Else: err_flag pulse, no frame.
    - Go to IDLE.
- p_data is held constant from IDLE exit through CAPTURE.
- Timeout counter increments each cycle in WAIT_BUSY/WAIT_DONE. On reaching TIMEOUT:
  - err_timeout pulse, pop FIFO (byte dropped), go to IDLE.
  - The IDLE guard !p_busy prevents relaunch while the unit is still running.
- Output: out_valid cleared on out_valid & out_ready. frame_count increments on the same handshake.
- Reset mid-operation: all state returns to reset values and FIFO contents are discarded. The parity unit may still be busy; the first launch after reset waits for p_busy=0.

## Timing
- Parity unit contract: it samples start in its wait state, enters INIT the next cycle, loads data_in at the end of INIT, and raises busy one cycle later. p_busy is therefore first seen high 2 cycles after the LAUNCH cycle.
- The result flag is set before busy falls and persists, so sampling in CAPTURE (first cycle with p_busy=0) is valid.
- Nominal latency, byte entering the empty FIFO to out_valid:
  - 1 cycle to IDLE decision.
  - LAUNCH.
  - Unit run (≈19 cycles of busy).
  - CAPTURE.
  - out_valid visible the cycle after CAPTURE.
- Throughput: one byte per unit run plus 4 cycles of overhead. No launch while out_valid is high, so backpressure stalls launches but not FIFO fill.
- err_timeout and err_flag never assert in the same cycle. Each is high exactly one cycle.

## Test plan
- Single byte 0xA5 (4 ones), PAR_ODD=0 → unit reports even. out_frame=0x0A5 (bit8=0), out_valid held until out_ready, frame_count=1.
- Byte 0x07 (3 ones), PAR_ODD=0 → out_frame=0x107. With PAR_ODD=1 the same byte → out_frame=0x007.
- Burst of 6 bytes with out_ready=1 and FIFO_DEPTH=4 → in_ready drops after 4 (+1 popped) entries. All 6 frames emerge in order. frame_count=6.
- out_ready=0 for 100 cycles after the first frame → exactly one frame pending, no second p_start, FIFO fills and in_ready=0. Releasing out_ready drains all bytes in order.
- p_busy tied to 0 → err_timeout pulses exactly TIMEOUT+2 cycles after p_start, byte dropped, next byte launched. With p_even=p_odd=1 → err_flag pulses, no frame.
- rst asserted during WAIT_DONE with p_busy=1 → outputs return to reset values immediately. After release, a new byte is not launched until p_busy falls.

Source files
------------

// File: rtl/parity_frame_sequencer.sv
// Byte-stream front end for the parity unit: buffers bytes in a small FIFO, runs the unit once
// per byte and emits {parity_bit, byte} frames over a valid/ready output.
module parity_frame_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 63,
    parameter bit          PAR_ODD    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [8:0]  out_frame,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        p_start,
    output logic [7:0]  p_data,
    input  logic        p_busy,
    input  logic        p_even,
    input  logic        p_odd,
    output logic        err_timeout,
    output logic        err_flag,
    output logic [15:0] frame_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [AW:0]   FullCount  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   CountOne   = 1;
    localparam logic [AW-1:0] PtrOne     = 1;
    localparam logic [CW-1:0] TimeoutVal = TIMEOUT[CW-1:0];
    localparam logic [CW-1:0] CntOne     = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StCapture
    } state_e;

    // Input FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop;

    // Sequencer state
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    p_data_q, p_data_d;
    logic [8:0]    out_frame_q, out_frame_d;
    logic          out_valid_q, out_valid_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_flag_q, err_flag_d;
    logic [15:0]   frame_count_q, frame_count_d;

    assign in_ready = (count_q != FullCount);
    assign push     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_q <= count_q + CountOne;
            end else if (pop && !push) begin
                count_q <= count_q - CountOne;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        p_data_d      = p_data_q;
        out_frame_d   = out_frame_q;
        out_valid_d   = out_valid_q;
        err_timeout_d = 1'b0;
        err_flag_d    = 1'b0;
        frame_count_d = frame_count_q;
        pop           = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d   = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                // !p_busy keeps us from relaunching a unit still finishing an abandoned run
                if ((count_q != '0) && !out_valid_q && !p_busy) begin
                    p_data_d = mem[rd_ptr_q];
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (cnt_q == TimeoutVal) begin
                    err_timeout_d = 1'b1;
                    pop           = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (p_busy) begin
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: begin
                if (cnt_q == TimeoutVal) begin
                    err_timeout_d = 1'b1;
                    pop           = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (!p_busy) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                pop = 1'b1;
                // Exactly one flag must be set for a trustworthy result
                if (p_even ^ p_odd) begin
                    out_frame_d = {(PAR_ODD ? p_even : p_odd), p_data_q};
                    out_valid_d = 1'b1;
                end else begin
                    err_flag_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            p_data_q      <= '0;
            out_frame_q   <= '0;
            out_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_flag_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            p_data_q      <= p_data_d;
            out_frame_q   <= out_frame_d;
            out_valid_q   <= out_valid_d;
            err_timeout_q <= err_timeout_d;
            err_flag_q    <= err_flag_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign p_start     = (state_q == StLaunch);
    assign p_data      = p_data_q;
    assign out_frame   = out_frame_q;
    assign out_valid   = out_valid_q;
    assign err_timeout = err_timeout_q;
    assign err_flag    = err_flag_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_parity_frame_sequencer.sv
// Bench for parity_frame_sequencer: a behavioural parity unit plus two DUTs (even / odd framing)
// running in lockstep on shared inputs.
module tb_parity_frame_sequencer;

    localparam int unsigned TIMEOUT = 63;
    localparam int          BUSY_LEN = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  out_frame;
    logic        out_valid;
    logic        out_ready;
    logic        p_start;
    logic [7:0]  p_data;
    logic        p_busy = 1'b0;
    logic        p_even = 1'b0;
    logic        p_odd  = 1'b0;
    logic        err_timeout;
    logic        err_flag;
    logic [15:0] frame_count;

    logic        in_ready1, out_valid1, p_start1, err_timeout1, err_flag1;
    logic [8:0]  out_frame1;
    logic [7:0]  p_data1;
    logic [15:0] frame_count1;

    logic no_busy;
    logic force_eq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parity_frame_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .PAR_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_frame(out_frame), .out_valid(out_valid), .out_ready(out_ready),
        .p_start(p_start), .p_data(p_data), .p_busy(p_busy), .p_even(p_even), .p_odd(p_odd),
        .err_timeout(err_timeout), .err_flag(err_flag), .frame_count(frame_count)
    );

    parity_frame_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .PAR_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_frame(out_frame1), .out_valid(out_valid1), .out_ready(out_ready),
        .p_start(p_start1), .p_data(p_data1), .p_busy(p_busy), .p_even(p_even), .p_odd(p_odd),
        .err_timeout(err_timeout1), .err_flag(err_flag1), .frame_count(frame_count1)
    );

    // Parity unit model: wait -> init (load data) -> busy for BUSY_LEN cycles; not reset by rst
    int         m_state = 0;
    int         m_cnt = 0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) begin
        case (m_state)
            0: if (p_start) m_state <= 1;
            1: begin
                m_data <= p_data;
                if (no_busy) begin
                    m_state <= 0;
                end else begin
                    p_busy  <= 1'b1;
                    m_cnt   <= BUSY_LEN;
                    m_state <= 2;
                end
            end
            default: begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 2) begin
                    p_even <= force_eq | ~(^m_data);
                    p_odd  <= force_eq | (^m_data);
                end
                if (m_cnt == 1) begin
                    p_busy  <= 1'b0;
                    m_state <= 0;
                end
            end
        endcase
    end

    // Event monitors
    int         cyc = 0;
    int         bad_start = 0;
    int         full_cycles = 0;
    int         start_q[$];
    int         to_q[$];
    int         flag_q[$];
    logic [8:0] got0[$];
    logic [8:0] got1[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (p_start) start_q.push_back(cyc);
        if (p_start && p_busy) bad_start <= bad_start + 1;
        if (err_timeout) to_q.push_back(cyc);
        if (err_flag) flag_q.push_back(cyc);
        if (out_valid && out_ready) begin
            got0.push_back(out_frame);
            got1.push_back(out_frame1);
        end
        if (!in_ready) full_cycles <= full_cycles + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] exp_frame(input logic [7:0] b, input bit odd);
        int ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(b[k]);
        if (odd) return {((ones % 2) == 0), b};
        return {((ones % 2) == 1), b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string name);
        int k = 0;
        while (got0.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(name, got0.size(), n);
    endtask

    task automatic do_reset();
        int k = 0;
        while (p_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got0.delete();
        got1.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [8:0] exp_even;
        logic [8:0] exp_odd;
    } vec_t;

    initial begin
        vec_t       vecs[6];
        logic [7:0] burst[6];
        int         s0, t0, fc0, k;

        vecs[0] = '{8'hA5, 9'h0A5, 9'h1A5};
        vecs[1] = '{8'h07, 9'h107, 9'h007};
        vecs[2] = '{8'h00, 9'h000, 9'h100};
        vecs[3] = '{8'hFF, 9'h0FF, 9'h1FF};
        vecs[4] = '{8'h01, 9'h101, 9'h001};
        vecs[5] = '{8'h80, 9'h180, 9'h080};
        burst   = '{8'h11, 8'h23, 8'h3C, 8'h80, 8'hFE, 8'h5A};

        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        no_busy = 1'b0; force_eq = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_in_ready", in_ready, 1);
        check("reset_out_frame", out_frame, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_p_start", p_start, 0);
        check("reset_p_data", p_data, 0);
        check("reset_err_timeout", err_timeout, 0);
        check("reset_err_flag", err_flag, 0);
        check("reset_frame_count", frame_count, 0);

        // Single-byte vectors, each held under backpressure before acceptance
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].data);
            k = 0;
            while (!out_valid && k < 300) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("vec%0d_frame_even", i), out_frame, vecs[i].exp_even);
            check($sformatf("vec%0d_frame_odd", i), out_frame1, vecs[i].exp_odd);
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_held", i), {out_valid, out_frame}, {1'b1, vecs[i].exp_even});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check($sformatf("vec%0d_valid_drop", i), out_valid, 0);
            check($sformatf("vec%0d_frame_count", i), frame_count, i + 1);
        end

        // Burst of 6 with a free-running sink
        do_reset();
        out_ready = 1'b1;
        fc0 = full_cycles;
        for (int i = 0; i < 6; i++) push(burst[i]);
        wait_frames(6, "burst_frames");
        @(negedge clk);
        check("burst_in_ready_dropped", (full_cycles > fc0), 1);
        for (int i = 0; i < 6 && i < got0.size(); i++) begin
            check($sformatf("burst%0d_even", i), got0[i], exp_frame(burst[i], 1'b0));
            check($sformatf("burst%0d_odd", i), got1[i], exp_frame(burst[i], 1'b1));
        end
        check("burst_frame_count", frame_count, 6);

        // Backpressure: one frame pending, FIFO fills, no further launch
        do_reset();
        out_ready = 1'b0;
        s0 = start_q.size();
        for (int i = 0; i < 5; i++) push(burst[i]);
        repeat (100) @(negedge clk);
        check("bp_single_launch", start_q.size() - s0, 1);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_pending_frame", out_frame, exp_frame(burst[0], 1'b0));
        out_ready = 1'b1;
        wait_frames(5, "bp_frames");
        @(negedge clk);
        for (int i = 0; i < 5 && i < got0.size(); i++) begin
            check($sformatf("bp%0d_frame", i), got0[i], exp_frame(burst[i], 1'b0));
        end
        check("bp_frame_count", frame_count, 5);

        // Unit never raises busy: both bytes time out
        do_reset();
        no_busy = 1'b1;
        s0 = start_q.size();
        t0 = to_q.size();
        push(8'h12);
        push(8'h34);
        k = 0;
        while (to_q.size() < t0 + 2 && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check("to_pulses", to_q.size() - t0, 2);
        check("to_launches", start_q.size() - s0, 2);
        if (to_q.size() >= t0 + 2 && start_q.size() >= s0 + 2) begin
            check("to0_latency", to_q[t0] - start_q[s0], TIMEOUT + 2);
            check("to1_latency", to_q[t0 + 1] - start_q[s0 + 1], TIMEOUT + 2);
        end
        check("to_no_frame", got0.size(), 0);
        check("to_in_ready", in_ready, 1);
        no_busy = 1'b0;

        // Inconsistent flags: byte dropped, then a good byte
        do_reset();
        force_eq = 1'b1;
        t0 = flag_q.size();
        push(8'h3C);
        k = 0;
        while (flag_q.size() == t0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("flag_pulses", flag_q.size() - t0, 1);
        check("flag_no_frame", {out_valid, frame_count}, 17'd0);
        force_eq = 1'b0;
        push(8'h3C);
        wait_frames(1, "flag_recover_frames");
        @(negedge clk);
        if (got0.size() > 0) check("flag_recover_frame", got0[0], 9'h03C);
        check("flag_recover_count", frame_count, 1);

        // Reset while the unit is busy
        got0.delete();
        got1.delete();
        push(8'h55);
        k = 0;
        while (!p_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_out_frame", out_frame, 0);
        check("rst_p_data", p_data, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_in_ready_valid", {in_ready, out_valid, p_start}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        s0 = start_q.size();
        push(8'h0F);
        wait_frames(1, "rst_frames");
        @(negedge clk);
        if (got0.size() > 0) check("rst_frame", got0[0], 9'h00F);
        check("rst_launches", start_q.size() - s0, 1);
        check("no_launch_while_busy", bad_start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
